bcd_sevenseg_scanner: RTL
=========================

Name: bcd_sevenseg_scanner

Overview:
- Consumer end of the BCD counter chain: takes NDIG packed BCD digits plus decimal points and drives a time-multiplexed common-anode 7-segment display.
- Captures each new value into a pending register and commits it to the display register only at frame boundaries, so no frame ever mixes old and new digits.
- Generates its own refresh timing and emits a per-frame strobe.

Parameters:
- NDIG, 4, number of digits (2..8); digit 0 is least significant, rightmost.
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- load  in  1  capture bcd_in/dp_in into pending register this cycle.
- bcd_in  in  4*NDIG  packed BCD; digit k = bcd_in[4k+3:4k].
- dp_in  in  NDIG  decimal point request per digit, 1 = lit.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NDIG  digit enables, active-low, one-hot-low.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - seg=7'h7F, dp=1, an=all 1s, frame_done=0.
  - refresh counter=0, digit index=0.
  - pending and display registers = 0, pending-valid flag = 0.
- Refresh counter runs 0..REFRESH_DIV-1 and wraps.
- At terminal count the digit index advances, wrapping NDIG-1 -> 0.
- Wrap cycle (index NDIG-1 -> 0, counter terminal):
  - frame_done=1 for exactly that cycle.
  - If pending-valid=1, display <= pending and pending-valid <= 0.
- load=1: pending <= {bcd_in, dp_in}, pending-valid <= 1.
  - Repeated loads within a frame: last one wins.
- load=1 on a wrap cycle: display <= bcd_in/dp_in directly; pending-valid ends 0.
- Outputs are registered from the current index and display register (1-cycle latency):
  - an[idx]=0, all other an bits = 1.
  - seg = decode(display digit idx); dp = ~display_dp[idx].
- Decode, active-low hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..15 (invalid BCD) = 3F (segment g only, "-").
- First edge after rst releases: an=~1 (digit 0 on), seg=40.
- Reset mid-operation: all state returns to reset values on that edge; any pending load is discarded.
- No anti-ghosting blank interval; an and seg change on the same edge.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero digit show seg=7F.
  - Digit 0 is never blanked; an all-zero display shows "0" in digit 0 only.
  - Digits holding invalid BCD count as nonzero.
  - dp on blanked digits still follows display_dp.
- Undefined: all digits are decoded, leading zeros shown as 40.

Test Plan (NDIG=4, REFRESH_DIV=4):
- Reset, then release -> an cycles E,D,B,7 with each held 4 clks; seg=40 throughout; frame_done pulses once every 16 clks on the 7->E transition.
- load bcd_in=16'h1234, dp_in=4'b0100 mid-frame -> display unchanged until the next frame_done.
  - Following frame: an=E seg=19; an=D seg=30; an=B seg=24 dp=0; an=7 seg=79.
- Two loads in one frame (16'h1111 then 16'h9876) -> next frame shows 9876 only; 1111 is never displayed.
- load 16'hA0F9 on the exact wrap cycle -> the frame starting that cycle shows digit0=10, digit1=3F, digit2=40, digit3=3F.
- rst asserted mid-frame while pending-valid=1 -> next edge gives an=F, seg=7F; after release the display shows 0000 and the pending value is never shown.
- LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 show seg=7F; digit1=12; digit0=40.
  - Load 16'h0000 -> only digit 0 shows 40.

Source files
------------

// File: rtl/bcd_sevenseg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner for NDIG packed BCD digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module bcd_sevenseg_scanner #(
   parameter int NDIG        = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [4*NDIG-1:0]    bcd_in,
   input  logic [NDIG-1:0]      dp_in,
   output logic [6:0]           seg,
   output logic                 dp,
   output logic [NDIG-1:0]      an,
   output logic                 frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NDIG);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(REFRESH_DIV - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*NDIG-1:0]   pend_bcd;
   logic [NDIG-1:0]     pend_dp;
   logic                pend_vld;
   logic [4*NDIG-1:0]   disp_bcd;
   logic [NDIG-1:0]     disp_dp;

   logic                tc;
   logic                wrap;
   logic                pre_wrap;
   logic [3:0]          cur_bcd;
   logic                cur_dp;
   logic                cur_blank;
   logic [6:0]          seg_next;
   logic [NDIG-1:0]     an_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign tc       = (cnt == CNT_LAST);
   assign wrap     = tc && (idx == IDX_LAST);
   // frame_done is registered, so decode the cycle before the wrap to land it on the wrap cycle
   assign pre_wrap = (cnt == CNT_PRE) && (idx == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
   logic [NDIG-1:0] blank_vec;
   logic            lead;

   always_comb begin
      lead      = 1'b1;
      blank_vec = '0;
      for (int k = NDIG - 1; k >= 1; k--) begin
         lead         = lead && (disp_bcd[4*k +: 4] == 4'd0);
         blank_vec[k] = lead;
      end
   end
`endif

   always_comb begin
      cur_bcd   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         if (idx == IW'(k)) begin
            cur_bcd = disp_bcd[4*k +: 4];
            cur_dp  = disp_dp[k];
`ifdef LEADING_ZERO_BLANK_EN
            cur_blank = blank_vec[k];
`endif
         end
      end
   end

   assign seg_next = cur_blank ? 7'h7F : decode(cur_bcd);
   assign an_next  = ~({{(NDIG-1){1'b0}}, 1'b1} << idx);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend_bcd   <= '0;
         pend_dp    <= '0;
         pend_vld   <= 1'b0;
         disp_bcd   <= '0;
         disp_dp    <= '0;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_next;
         dp         <= ~cur_dp;
         an         <= an_next;
         frame_done <= pre_wrap;

         cnt <= tc ? '0 : cnt + CW'(1);
         if (tc)
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

         // commits happen only at the wrap so a frame never mixes old and new digits
         if (wrap) begin
            pend_vld <= 1'b0;
            if (load) begin
               disp_bcd <= bcd_in;
               disp_dp  <= dp_in;
            end else if (pend_vld) begin
               disp_bcd <= pend_bcd;
               disp_dp  <= pend_dp;
            end
         end else if (load) begin
            pend_bcd <= bcd_in;
            pend_dp  <= dp_in;
            pend_vld <= 1'b1;
         end
      end
   end

endmodule
